// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
//
// Elastic, pipelined WIDTH-bit ALU. Operands are selected and the operation is
// evaluated combinationally on the input side; the result and its flags are
// captured into stage 1 on acceptance and then ripple through STAGES-1 further
// delay registers, each with its own valid bit. Bubbles collapse: a stage loads
// whenever it is empty or is handing its contents forward in the same cycle.
// The result of every retired operation is kept in last_result and can be fed
// back as the A operand.
//
// Ports
//   clkpos       system clock, rising-edge active
//   reset        synchronous, active-high reset
//   in_valid     operation offered
//   in_ready     operation accepted when in_valid & in_ready at a rising edge
//   op           000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 SLTU,
//                110 XOR, 111 NOR
//   a_sel        A operand: 0 a, 1 pc_in, 2 last_result, 3 zero
//   b_sel        B operand: 0 b, 1 instr_in, 2 instr_in >> 1, 3 constant 2
//   a, b         general operands
//   pc_in        program counter operand
//   instr_in     instruction-word operand
//   out_valid    result available
//   out_ready    consumer accepts result when out_valid & out_ready
//   result       operation result
//   zero         result == 0
//   carry        ADD carry-out / SUB no-borrow, 0 otherwise
//   ovf          signed overflow for ADD/SUB, 0 otherwise
//   last_result  result of the most recently retired operation
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3
) (
    input  logic             clkpos,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [1:0]       a_sel,
    input  logic [1:0]       b_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] instr_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic [WIDTH-1:0] last_result
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SLT  = 3'b100,
        OP_SLTU = 3'b101,
        OP_XOR  = 3'b110,
        OP_NOR  = 3'b111
    } op_e;

    // One pipeline word: the result together with the flags that travel with it.
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             carry;
        logic             ovf;
    } alu_word_t;

    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   dif_ext;
    op_e              op_code;
    alu_word_t        alu_word;

    alu_word_t         stage_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] capture;
    logic              accept;
    logic              retire;

    // -----------------------------------------------------------------------
    // Operand selection
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinationally written signal gets a default before the
        // case statements so that no path leaves it unassigned (no latch).
        opnd_a = '0;
        opnd_b = '0;
        case (a_sel)
            2'd0:    opnd_a = a;
            2'd1:    opnd_a = pc_in;
            2'd2:    opnd_a = last_result;   // retired value only, no forwarding
            default: opnd_a = '0;
        endcase
        case (b_sel)
            2'd0:    opnd_b = b;
            2'd1:    opnd_b = instr_in;
            2'd2:    opnd_b = instr_in >> 1; // logical, MSB fills with 0
            default: opnd_b = WIDTH'(2);
        endcase
    end

    // SUB is formed as A + ~B + 1 so that bit WIDTH is the no-borrow carry.
    assign sum_ext = {1'b0, opnd_a} + {1'b0, opnd_b};
    assign dif_ext = {1'b0, opnd_a} + {1'b0, ~opnd_b} + (WIDTH + 1)'(1);
    assign op_code = op_e'(op);

    // -----------------------------------------------------------------------
    // ALU evaluation
    // -----------------------------------------------------------------------
    always_comb begin
        alu_word = '0;
        case (op_code)
            OP_AND: alu_word.res = opnd_a & opnd_b;
            OP_OR:  alu_word.res = opnd_a | opnd_b;
            OP_ADD: begin
                alu_word.res   = sum_ext[MSB:0];
                alu_word.carry = sum_ext[WIDTH];
                alu_word.ovf   = (opnd_a[MSB] == opnd_b[MSB]) &&
                                 (sum_ext[MSB] != opnd_a[MSB]);
            end
            OP_SUB: begin
                alu_word.res   = dif_ext[MSB:0];
                alu_word.carry = dif_ext[WIDTH];
                alu_word.ovf   = (opnd_a[MSB] != opnd_b[MSB]) &&
                                 (dif_ext[MSB] != opnd_a[MSB]);
            end
            // True comparisons, independent of the subtractor's sign bit.
            OP_SLT:  alu_word.res = WIDTH'($signed(opnd_a) < $signed(opnd_b));
            OP_SLTU: alu_word.res = WIDTH'(opnd_a < opnd_b);
            OP_XOR:  alu_word.res = opnd_a ^ opnd_b;
            OP_NOR:  alu_word.res = ~(opnd_a | opnd_b);
        endcase
        alu_word.zero = (alu_word.res == '0);
    end

    // -----------------------------------------------------------------------
    // Elastic flow control
    //
    // Walk from the output stage back to stage 1: a stage may capture when it
    // is empty or when whatever it holds moves on this cycle, and it moves on
    // exactly when the stage after it may capture (out_ready for the last).
    // -----------------------------------------------------------------------
    always_comb begin
        logic downstream_free;
        capture         = '0;
        downstream_free = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            capture[k]      = !valid_q[k] || downstream_free;
            downstream_free = capture[k];
        end
    end

    assign in_ready  = !reset && capture[0];
    assign accept    = in_valid && in_ready;

    assign out_valid = valid_q[STAGES-1];
    assign result    = stage_q[STAGES-1].res;
    assign zero      = stage_q[STAGES-1].zero;
    assign carry     = stage_q[STAGES-1].carry;
    assign ovf       = stage_q[STAGES-1].ovf;
    assign retire    = out_valid && out_ready;

    // -----------------------------------------------------------------------
    // Pipeline registers and feedback register
    // -----------------------------------------------------------------------
    always_ff @(posedge clkpos) begin
        // NOTE: sequential state uses non-blocking assignments so every stage
        // samples its neighbour's pre-edge value.
        if (reset) begin
            valid_q <= '0;
            // NOTE: the stage data registers are cleared as well, because the
            // presented result and flags must read zero out of reset.
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
            last_result <= '0;
        end else begin
            if (capture[0]) begin
                valid_q[0] <= accept;
                if (accept) begin
                    stage_q[0] <= alu_word;
                end
            end
            // Data only moves with a valid word, so the output holds its last
            // value across bubbles.
            for (int k = 1; k < STAGES; k++) begin
                if (capture[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        stage_q[k] <= stage_q[k-1];
                    end
                end
            end
            if (retire) begin
                last_result <= stage_q[STAGES-1].res;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
//
// Bench for alu_pipe. A 16-bit, 3-stage instance takes a table of directed
// vectors, backpressure / feedback / mid-flight reset sequences and a random
// phase; every accepted operation is predicted by an arithmetic reference
// model and queued, and every retirement is compared against the queue head.
// A 32-bit, 1-stage instance covers single-cycle latency and 32-bit wrap.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int W16 = 16;
    localparam int S16 = 3;

    // ---------------- 16-bit / 3-stage instance ----------------
    logic        clkpos = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [15:0] a, b, pc_in, instr_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        zero, carry, ovf;
    logic [15:0] last_result;

    // ---------------- 32-bit / 1-stage instance ----------------
    logic        reset_w;
    logic        in_valid_w;
    logic        in_ready_w;
    logic [2:0]  op_w;
    logic [1:0]  a_sel_w;
    logic [1:0]  b_sel_w;
    logic [31:0] a_w, b_w, pc_w, instr_w;
    logic        out_valid_w;
    logic        out_ready_w;
    logic [31:0] result_w;
    logic        zero_w, carry_w, ovf_w;
    logic [31:0] last_result_w;

    alu_pipe #(.WIDTH(W16), .STAGES(S16)) u_dut (
        .clkpos(clkpos), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a_sel(a_sel), .b_sel(b_sel),
        .a(a), .b(b), .pc_in(pc_in), .instr_in(instr_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .ovf(ovf),
        .last_result(last_result)
    );

    alu_pipe #(.WIDTH(32), .STAGES(1)) u_dut_w (
        .clkpos(clkpos), .reset(reset_w),
        .in_valid(in_valid_w), .in_ready(in_ready_w),
        .op(op_w), .a_sel(a_sel_w), .b_sel(b_sel_w),
        .a(a_w), .b(b_w), .pc_in(pc_w), .instr_in(instr_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .result(result_w), .zero(zero_w), .carry(carry_w), .ovf(ovf_w),
        .last_result(last_result_w)
    );

    always #5 clkpos = ~clkpos;

    // ---------------- bookkeeping ----------------
    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  as;
        logic [1:0]  bs;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        o;
        string       name;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    exp_t              sb [$];
    int                ret_cycles [$];
    logic [15:0]       ret_vals [$];
    longint unsigned   model_last;
    logic              accepted, got_out;
    int                acc_cyc, out_cyc;
    logic [15:0]       obs_res;
    logic              obs_z, obs_c, obs_o;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: integer arithmetic on the operand values.
    function automatic exp_t model(input int w, input logic [2:0] fop,
                                   input longint unsigned av, input longint unsigned bv);
        exp_t            e;
        longint unsigned m, full;
        longint          sa, sbv, sr, lo, hi;
        m   = (64'd1 << w) - 64'd1;
        hi  = (longint'(1) << (w - 1)) - 1;
        lo  = -(longint'(1) << (w - 1));
        sa  = longint'(av);
        sbv = longint'(bv);
        if (sa > hi)  sa  = sa  - (longint'(1) << w);
        if (sbv > hi) sbv = sbv - (longint'(1) << w);
        e.c  = 1'b0;
        e.o  = 1'b0;
        full = 0;
        case (fop)
            3'd0: full = av & bv;
            3'd1: full = av | bv;
            3'd2: begin
                full = av + bv;
                e.c  = ((full >> w) != 0);
                sr   = sa + sbv;
                e.o  = (sr < lo) || (sr > hi);
            end
            3'd3: begin
                full = av + (m - bv) + 64'd1;
                e.c  = ((full >> w) != 0);
                sr   = sa - sbv;
                e.o  = (sr < lo) || (sr > hi);
            end
            3'd4: full = (sa < sbv) ? 64'd1 : 64'd0;
            3'd5: full = (av < bv) ? 64'd1 : 64'd0;
            3'd6: full = av ^ bv;
            default: full = ~(av | bv);
        endcase
        e.res = 32'(full & m);
        e.z   = ((full & m) == 0);
        return e;
    endfunction

    function automatic longint unsigned pick_a(input logic [1:0] s, input longint unsigned av,
                                               input longint unsigned pcv, input longint unsigned lastv);
        case (s)
            2'd0:    return av;
            2'd1:    return pcv;
            2'd2:    return lastv;
            default: return 0;
        endcase
    endfunction

    function automatic longint unsigned pick_b(input logic [1:0] s, input longint unsigned bv,
                                               input longint unsigned iv);
        case (s)
            2'd0:    return bv;
            2'd1:    return iv;
            2'd2:    return iv / 2;
            default: return 2;
        endcase
    endfunction

    // One clock cycle of the 16-bit instance: sample at the falling edge,
    // score handshakes, then step to just after the next rising edge.
    task automatic cycle();
        longint unsigned old_last;
        exp_t            e;
        @(negedge clkpos);
        accepted = 1'b0;
        got_out  = 1'b0;
        if (reset) begin
            check("in_ready_during_reset", in_ready, 0);
            sb.delete();
            model_last = 0;
        end else begin
            old_last = model_last;
            check("last_result", last_result, model_last);
            check("in_ready", in_ready, !((sb.size() == S16) && !out_ready));
            if (out_valid && out_ready) begin
                ret_cycles.push_back(cyc);
                ret_vals.push_back(result);
                check("retire_has_pending_op", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("zero", zero, e.z);
                    check("carry", carry, e.c);
                    check("ovf", ovf, e.o);
                    model_last = e.res;
                end
                obs_res = result;
                obs_z   = zero;
                obs_c   = carry;
                obs_o   = ovf;
                got_out = 1'b1;
                out_cyc = cyc;
            end
            if (in_valid && in_ready) begin
                e = model(W16, op, pick_a(a_sel, a, pc_in, old_last), pick_b(b_sel, b, instr_in));
                sb.push_back(e);
                accepted = 1'b1;
                acc_cyc  = cyc;
            end
        end
        @(posedge clkpos);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [2:0] o, input logic [1:0] as, input logic [1:0] bs,
                         input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] pcv, input logic [15:0] iv);
        int n;
        op = o; a_sel = as; b_sel = bs; a = av; b = bv; pc_in = pcv; instr_in = iv;
        in_valid = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!accepted && n < 40);
        check("issue_accepted", accepted, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!got_out && n < 40);
        check("output_arrived", got_out, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            cycle();
            n++;
        end
        check("drained", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bp_exp [5];
        int          rc;

        //            op    as    bs    a         b         pc        instr     res       z     c     o
        vecs[0]  = '{3'd2, 2'd0, 2'd0, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1, "add_ovf"};
        vecs[1]  = '{3'd3, 2'd0, 2'd0, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, "sub_eq"};
        vecs[2]  = '{3'd4, 2'd0, 2'd0, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, "slt_neg"};
        vecs[3]  = '{3'd5, 2'd0, 2'd0, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "sltu_big"};
        vecs[4]  = '{3'd3, 2'd0, 2'd0, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 16'hFFFE, 1'b0, 1'b0, 1'b0, "sub_borrow"};
        vecs[5]  = '{3'd3, 2'd0, 2'd0, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1'b1, "sub_ovf"};
        vecs[6]  = '{3'd2, 2'd0, 2'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, "add_wrap"};
        vecs[7]  = '{3'd4, 2'd0, 2'd0, 16'h0001, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "slt_pos"};
        vecs[8]  = '{3'd5, 2'd0, 2'd0, 16'h0001, 16'h8000, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, "sltu_small"};
        vecs[9]  = '{3'd0, 2'd0, 2'd0, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 16'hF000, 1'b0, 1'b0, 1'b0, "and"};
        vecs[10] = '{3'd6, 2'd0, 2'd0, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, "xor"};
        vecs[11] = '{3'd7, 2'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, "nor"};
        vecs[12] = '{3'd2, 2'd1, 2'd3, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0102, 1'b0, 1'b0, 1'b0, "mux_pc_two"};
        vecs[13] = '{3'd1, 2'd3, 2'd2, 16'h0000, 16'h0000, 16'h0000, 16'h8003, 16'h4001, 1'b0, 1'b0, 1'b0, "mux_shift_or"};
        vecs[14] = '{3'd2, 2'd0, 2'd1, 16'h0001, 16'h0000, 16'h0000, 16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, "mux_instr"};

        bp_exp = '{16'h0002, 16'h0004, 16'h0006, 16'h1245, 16'hAAAA};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a_sel = '0; b_sel = '0; a = '0; b = '0; pc_in = '0; instr_in = '0;
        reset_w = 1'b1; in_valid_w = 1'b0; out_ready_w = 1'b1;
        op_w = '0; a_sel_w = '0; b_sel_w = '0; a_w = '0; b_w = '0; pc_w = '0; instr_w = '0;
        model_last = 0;

        // ---- reset state ----
        repeat (3) cycle();
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_carry", carry, 0);
        check("rst_ovf", ovf, 0);
        check("rst_last_result", last_result, 0);
        check("rst_in_ready_after_release", in_ready, 1);

        // ---- directed vector table ----
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].as, vecs[i].bs, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].instr);
            wait_out();
            check({vecs[i].name, "_res"}, obs_res, vecs[i].res);
            check({vecs[i].name, "_zero"}, obs_z, vecs[i].z);
            check({vecs[i].name, "_carry"}, obs_c, vecs[i].c);
            check({vecs[i].name, "_ovf"}, obs_o, vecs[i].o);
            if (i == 0) check("latency_first_op", out_cyc - acc_cyc, S16);
        end

        // ---- backpressure: fill, hold, then drain with same-cycle accept ----
        out_ready = 1'b0;
        issue(3'd2, 2'd0, 2'd0, 16'd1, 16'd1, 16'd0, 16'd0);
        issue(3'd2, 2'd0, 2'd0, 16'd2, 16'd2, 16'd0, 16'd0);
        issue(3'd2, 2'd0, 2'd0, 16'd3, 16'd3, 16'd0, 16'd0);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_head_result", result, 16'h0002);
        op = 3'd2; a_sel = 2'd2; b_sel = 2'd0; a = 16'd0; b = 16'h0010;
        in_valid = 1'b1;
        repeat (2) begin
            cycle();
            check("bp_no_accept", accepted, 0);
            check("bp_result_held", result, 16'h0002);
        end
        ret_cycles.delete();
        ret_vals.delete();
        out_ready = 1'b1;
        issue(3'd2, 2'd2, 2'd0, 16'd0, 16'h0010, 16'd0, 16'd0);
        check("bp_accept_with_retire", acc_cyc, ret_cycles.size() > 0 ? ret_cycles[0] : -1);
        issue(3'd6, 2'd0, 2'd0, 16'hA5A5, 16'h0F0F, 16'd0, 16'd0);
        drain();
        check("bp_retire_count", ret_vals.size(), 5);
        if (ret_vals.size() == 5) begin
            for (int i = 0; i < 5; i++) check("bp_order", ret_vals[i], bp_exp[i]);
            for (int i = 1; i < 5; i++) check("bp_consecutive", ret_cycles[i] - ret_cycles[i-1], 1);
        end

        // ---- feedback through last_result ----
        issue(3'd2, 2'd0, 2'd0, 16'd3, 16'd4, 16'd0, 16'd0);
        wait_out();
        check("fb_producer", obs_res, 16'd7);
        issue(3'd2, 2'd2, 2'd0, 16'd0, 16'd1, 16'd0, 16'd0);
        wait_out();
        check("fb_dependent", obs_res, 16'd8);
        cycle();
        check("fb_last_result", last_result, 16'd8);
        issue(3'd2, 2'd0, 2'd0, 16'd10, 16'd20, 16'd0, 16'd0);
        issue(3'd2, 2'd2, 2'd0, 16'd0, 16'd1, 16'd0, 16'd0);
        wait_out();
        check("fb_inflight_producer", obs_res, 16'd30);
        wait_out();
        check("fb_inflight_stale", obs_res, 16'd9);
        cycle();

        // ---- reset with two ops in flight ----
        issue(3'd2, 2'd0, 2'd0, 16'd1, 16'd1, 16'd0, 16'd0);
        issue(3'd2, 2'd0, 2'd0, 16'd2, 16'd2, 16'd0, 16'd0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        rc = ret_cycles.size();
        repeat (6) cycle();
        check("rst_mid_no_output", ret_cycles.size() - rc, 0);
        check("rst_mid_last_zero", last_result, 0);
        issue(3'd2, 2'd0, 2'd0, 16'h0011, 16'h0022, 16'd0, 16'd0);
        wait_out();
        check("rst_mid_latency", out_cyc - acc_cyc, S16);
        check("rst_mid_result", obs_res, 16'h0033);

        // ---- random traffic against the model ----
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            op        = 3'($urandom);
            a_sel     = 2'($urandom);
            b_sel     = 2'($urandom);
            a         = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            b         = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
            pc_in     = 16'($urandom);
            instr_in  = 16'($urandom);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // ---- 32-bit, single-stage instance ----
        check("w32_rst_in_ready", in_ready_w, 0);
        check("w32_rst_out_valid", out_valid_w, 0);
        check("w32_rst_last_result", last_result_w, 0);
        reset_w = 1'b0;
        #1;
        check("w32_in_ready_release", in_ready_w, 1);
        op_w = 3'd2; a_w = 32'hFFFF_FFFF; b_w = 32'd1; in_valid_w = 1'b1;
        @(posedge clkpos);
        #1;
        in_valid_w = 1'b0;
        check("w32_latency_valid", out_valid_w, 1);
        check("w32_wrap_result", result_w, 32'd0);
        check("w32_wrap_carry", carry_w, 1);
        check("w32_wrap_zero", zero_w, 1);
        check("w32_wrap_ovf", ovf_w, 0);
        a_w = 32'h7FFF_FFFF; in_valid_w = 1'b1;
        @(posedge clkpos);
        #1;
        in_valid_w = 1'b0;
        check("w32_ovf_valid", out_valid_w, 1);
        check("w32_ovf_result", result_w, 32'h8000_0000);
        check("w32_ovf_flag", ovf_w, 1);
        check("w32_ovf_carry", carry_w, 0);
        @(posedge clkpos);
        #1;
        check("w32_drained", out_valid_w, 0);
        check("w32_last_result", last_result_w, 32'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
